sdram_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_slot_phase.sv | 36 +++
 rtl/sdram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM slot arbiter and its phase tracker.
package sdram_arb_pkg;

  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 8;
  localparam int NUM_PORTS = 3;

  localparam logic [2:0] SLOT_LAST = 3'd7;

  typedef enum logic [1:0] {
    PORT_VID  = 2'd0,
    PORT_CPU  = 2'd1,
    PORT_LDR  = 2'd2,
    PORT_NONE = 2'd3
  } port_t;

endpackage

// File: rtl/sdram_slot_phase.sv
// Tracks the SDRAM controller's 8-phase slot counter from clkref and flags the
// last cycle of each slot.
module sdram_slot_phase
  import sdram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clkref,
  output logic [2:0] ph,
  output logic       slot_end
);

  logic advance;

  // Phase 0 waits for clkref high and phase 7 waits for clkref low, so the
  // counter locks onto the controller within one clkref period.
  always_comb begin
    advance = 1'b1;
    if (ph == SLOT_LAST) begin
      advance = ~clkref;
    end else if (ph == 3'd0) begin
      advance = clkref;
    end
  end

  assign slot_end = (ph == SLOT_LAST) && advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= 3'd0;
    end else if (advance) begin
      ph <= ph + 3'd1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port slot scheduler in front of the single-port SDRAM controller:
// video has priority, CPU and loader share round-robin, with forced refresh slots.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int INIT_SLOTS  = 32,
  parameter int REFRESH_MAX = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkref,
  input  logic              init,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_din,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_dout,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_din,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_dout,
  input  logic              p2_req,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_din,
  output logic              p2_ack,
  output logic [DATA_W-1:0] p2_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_oe,
  output logic              mem_we
);

  localparam int HOLD_W = $clog2(INIT_SLOTS + 1);
  localparam int REF_W  = $clog2(REFRESH_MAX + 1);

  logic [2:0]           slot_ph;
  logic                 slot_end;
  logic [NUM_PORTS-1:0] req_vec, we_vec, eligible;
  logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
  logic [DATA_W-1:0]    din_arr  [NUM_PORTS];

  port_t                owner_reg, owner_next, rr_ptr_reg, rr_ptr_next, winner;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [REF_W-1:0]     refresh_reg, refresh_next;
  logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]    mem_din_reg, mem_din_next;
  logic                 mem_oe_reg, mem_oe_next, mem_we_reg, mem_we_next;
  logic [NUM_PORTS-1:0] ack_reg, ack_next;
  logic [DATA_W-1:0]    dout_reg [NUM_PORTS];
  logic [DATA_W-1:0]    dout_next [NUM_PORTS];

  sdram_slot_phase u_phase (
    .clk     (clk),
    .reset   (reset),
    .clkref  (clkref),
    .ph      (slot_ph),
    .slot_end(slot_end)
  );

  assign req_vec  = {p2_req, p1_req, p0_req};
  assign we_vec   = {p2_we, p1_we, p0_we};
  assign addr_arr = '{p0_addr, p1_addr, p2_addr};
  assign din_arr  = '{p0_din, p1_din, p2_din};

  // The owner of the ending slot is masked so a request still high during its
  // ack cycle is not serviced a second time.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_vec[i] && (owner_reg != port_t'(i));
    end
    winner = PORT_NONE;
    if (init || hold_reg != '0 || refresh_reg == REF_W'(REFRESH_MAX)) begin
      winner = PORT_NONE;
    end else if (eligible[PORT_VID]) begin
      winner = PORT_VID;
    end else if (rr_ptr_reg == PORT_CPU) begin
      winner = eligible[PORT_CPU] ? PORT_CPU : (eligible[PORT_LDR] ? PORT_LDR : PORT_NONE);
    end else begin
      winner = eligible[PORT_LDR] ? PORT_LDR : (eligible[PORT_CPU] ? PORT_CPU : PORT_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg    <= PORT_NONE;
      rr_ptr_reg   <= PORT_CPU;
      hold_reg     <= HOLD_W'(INIT_SLOTS);
      refresh_reg  <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      mem_oe_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      ack_reg      <= '0;
      dout_reg     <= '{default: '0};
    end else begin
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_reg     <= hold_next;
      refresh_reg  <= refresh_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
      mem_oe_reg   <= mem_oe_next;
      mem_we_reg   <= mem_we_next;
      ack_reg      <= ack_next;
      dout_reg     <= dout_next;
    end
  end

  always_comb begin
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_next     = hold_reg;
    refresh_next  = refresh_reg;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    mem_oe_next   = mem_oe_reg;
    mem_we_next   = mem_we_reg;
    ack_next      = '0;
    dout_next     = dout_reg;
    if (slot_end) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (owner_reg == port_t'(i)) begin
          ack_next[i] = 1'b1;
          if (mem_oe_reg) dout_next[i] = mem_dout;
        end
      end
      if (hold_reg != '0) hold_next = hold_reg - HOLD_W'(1);
      owner_next = winner;
      if (winner == PORT_NONE) begin
        // Idle slot: controller performs its auto-refresh here.
        mem_oe_next  = 1'b0;
        mem_we_next  = 1'b0;
        refresh_next = '0;
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (winner == port_t'(i)) begin
            mem_addr_next = addr_arr[i];
            mem_din_next  = din_arr[i];
            mem_we_next   = we_vec[i];
            mem_oe_next   = ~we_vec[i];
          end
        end
        refresh_next = refresh_reg + REF_W'(1);
        if (winner != PORT_VID) rr_ptr_next = (rr_ptr_reg == PORT_CPU) ? PORT_LDR : PORT_CPU;
      end
    end
    if (init) hold_next = HOLD_W'(INIT_SLOTS);
  end

  always_comb begin
    mem_addr = mem_addr_reg;
    mem_din  = mem_din_reg;
    mem_oe   = mem_oe_reg;
    mem_we   = mem_we_reg;
    p0_ack   = ack_reg[0];
    p1_ack   = ack_reg[1];
    p2_ack   = ack_reg[2];
    p0_dout  = dout_reg[0];
    p1_dout  = dout_reg[1];
    p2_dout  = dout_reg[2];
  end

  assert property (@(posedge clk) disable iff (reset) slot_end |-> slot_ph == SLOT_LAST);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: slot-level reference model, grant-pattern table and
// directed corner sequences, followed by random multi-port traffic.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int INIT_SLOTS  = 32;
  localparam int REFRESH_MAX = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clkref = 1'b0;
  logic init = 1'b0;
  logic req [3];
  logic we [3];
  logic [ADDR_W-1:0] addr [3];
  logic [DATA_W-1:0] din [3];
  logic ack [3];
  logic [DATA_W-1:0] dout [3];
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;
  logic mem_oe, mem_we;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 0;
  bit clkref_stop = 0;

  // memory behind the controller, and the model's own view of the same memory
  logic [7:0] ctl_mem [4096];
  bit         ctl_valid [4096];
  logic [7:0] ref_mem [4096];
  bit         ref_valid [4096];

  // reference model state
  int m_ph, m_owner, m_ptr, m_grants, m_hold;
  bit m_slot_end;
  logic e_oe, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_din;
  bit e_ack [3];
  logic [DATA_W-1:0] e_dout [3];

  typedef struct {
    logic [2:0] mask;
    int exp [10];
  } vec_t;
  vec_t tbl [5];

  sdram_arbiter #(.INIT_SLOTS(INIT_SLOTS), .REFRESH_MAX(REFRESH_MAX)) dut (
    .clk(clk), .reset(reset), .clkref(clkref), .init(init),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_din(din[0]), .p0_ack(ack[0]), .p0_dout(dout[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_din(din[1]), .p1_ack(ack[1]), .p1_dout(dout[1]),
    .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]), .p2_din(din[2]), .p2_ack(ack[2]), .p2_dout(dout[2]),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_oe(mem_oe), .mem_we(mem_we)
  );

  function automatic logic [7:0] dflt(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_valid[a[11:0]] ? ref_mem[a[11:0]] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever #5 clk = ~clk;

  // 14 MHz reference: 4 clk high, 4 clk low; can be frozen low
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      clkref = clkref_stop ? 1'b0 : cnt[2];
    end
  end

  // controller stand-in: writes while we is high, read data follows the address
  always @(posedge clk) begin
    if (mem_we) begin
      ctl_mem[mem_addr[11:0]]   <= mem_din;
      ctl_valid[mem_addr[11:0]] <= 1'b1;
    end
    mem_dout <= ctl_valid[mem_addr[11:0]] ? ctl_mem[mem_addr[11:0]] : dflt(mem_addr);
  end

  // Slot-level model: once per slot boundary, complete the current owner and
  // pick the next one from the priority / round-robin / refresh / holdoff rules.
  task automatic model_step();
    int win, first, second;
    m_slot_end = 0;
    for (int p = 0; p < 3; p++) e_ack[p] = 0;
    if (reset) begin
      m_ph = 0; m_owner = -1; m_ptr = 1; m_grants = 0; m_hold = INIT_SLOTS;
      e_oe = 0; e_we = 0; e_addr = '0; e_din = '0;
      for (int p = 0; p < 3; p++) e_dout[p] = '0;
      return;
    end
    m_slot_end = (m_ph == 7) && !clkref;
    if (m_ph == 0) m_ph = clkref ? 1 : 0;
    else if (m_ph == 7) m_ph = clkref ? 7 : 0;
    else m_ph = m_ph + 1;
    if (m_slot_end) begin
      if (m_owner >= 0) begin
        e_ack[m_owner] = 1;
        if (!e_we) e_dout[m_owner] = ref_read(e_addr);
      end
      win = -1;
      if (!init && m_hold == 0 && m_grants < REFRESH_MAX) begin
        if (req[0] && m_owner != 0) win = 0;
        else begin
          first = m_ptr;
          second = 3 - m_ptr;
          if (req[first] && m_owner != first) win = first;
          else if (req[second] && m_owner != second) win = second;
        end
      end
      if (win >= 0) begin
        e_addr = addr[win]; e_din = din[win]; e_we = we[win]; e_oe = !we[win];
        m_grants++;
        if (win != 0) m_ptr = 3 - m_ptr;
        if (we[win]) begin
          ref_mem[addr[win][11:0]] = din[win];
          ref_valid[addr[win][11:0]] = 1;
        end
      end else begin
        e_oe = 0; e_we = 0; m_grants = 0;
      end
      m_owner = win;
      if (!init && m_hold > 0) m_hold--;
    end
    if (init) m_hold = INIT_SLOTS;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // cycle-by-cycle scoreboard against the model
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("strobes", {mem_oe, mem_we, mem_addr, mem_din, ack[0], ack[1], ack[2]},
            {e_oe, e_we, e_addr, e_din, e_ack[0], e_ack[1], e_ack[2]});
      check("douts", {dout[0], dout[1], dout[2]}, {e_dout[0], e_dout[1], e_dout[2]});
    end
  end

  task automatic wait_slot();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_slot_end && n < 40);
    if (!m_slot_end) begin
      vectors++; miscompares++;
      $display("FAIL slot_timeout: got no slot end in %0d clk, expected one", n);
    end
  endtask

  task automatic wait_ack(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[p] !== 1'b1 && n < 64);
    check($sformatf("ack_wait_p%0d", p), ack[p], 1);
  endtask

  task automatic new_txn(input int p);
    addr[p] = 25'($urandom_range(0, 31));
    we[p]   = 1'($urandom_range(0, 1));
    din[p]  = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int n, obs, acks;
    tbl[0].mask = 3'b110; tbl[0].exp = '{1, 2, 1, 2, 1, 2, 3, 1, 2, 1};
    tbl[1].mask = 3'b011; tbl[1].exp = '{0, 1, 0, 1, 0, 1, 3, 0, 1, 0};
    tbl[2].mask = 3'b001; tbl[2].exp = '{0, 3, 0, 3, 0, 3, 0, 3, 0, 3};
    tbl[3].mask = 3'b101; tbl[3].exp = '{0, 2, 0, 2, 0, 2, 3, 0, 2, 0};
    tbl[4].mask = 3'b000; tbl[4].exp = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    for (int p = 0; p < 3; p++) begin
      req[p] = 0; we[p] = 0; addr[p] = '0; din[p] = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check_en = 1;
    check("reset_state", {mem_oe, mem_we, mem_addr, mem_din, ack[0], ack[1], ack[2]}, '0);
    check("reset_dout", {dout[0], dout[1], dout[2]}, '0);
    check("reset_ph", dut.u_phase.ph, 0);
    reset = 0;
    repeat (34) wait_slot();

    // grant patterns for held request sets (reads, port number in addr[24:23])
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < 3; p++) begin
        addr[p] = (25'(p) << 23) | 25'(64 + p);
        we[p] = 0;
        req[p] = tbl[i].mask[p];
      end
      for (int k = 0; k < 10; k++) begin
        wait_slot();
        obs = (mem_oe || mem_we) ? int'(mem_addr[24:23]) : 3;
        check($sformatf("grant_tbl%0d_slot%0d", i, k), obs, tbl[i].exp[k]);
      end
      for (int p = 0; p < 3; p++) req[p] = 0;
      repeat (2) wait_slot();
    end

    // loader write then CPU read of the same byte
    addr[2] = 25'h000123; din[2] = 8'hA5; we[2] = 1; req[2] = 1;
    wait_ack(2);
    req[2] = 0;
    addr[1] = 25'h000123; we[1] = 0; req[1] = 1;
    wait_ack(1);
    check("read_after_write", dout[1], 8'hA5);
    req[1] = 0;
    repeat (2) wait_slot();

    // init holdoff
    init = 1;
    repeat (10) @(negedge clk);
    init = 0;
    addr[1] = 25'h000567; we[1] = 0; req[1] = 1;
    n = 0;
    while (n < 40) begin
      wait_slot();
      if (mem_oe) break;
      n++;
    end
    check("init_idle_slots", n, INIT_SLOTS);
    check("init_grant_oe", mem_oe, 1);
    check("init_grant_addr", mem_addr, 25'h000567);
    repeat (8) @(negedge clk);
    check("init_ack", ack[1], 1);
    check("init_dout", dout[1], dflt(25'h000567));
    req[1] = 0;
    repeat (2) wait_slot();

    // clkref frozen low: phase parks at 0 and no slot completes
    addr[0] = 25'h000010; we[0] = 0; req[0] = 1;
    wait_slot();
    clkref_stop = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 10) begin
        check("clkref_stop_ph", dut.u_phase.ph, 0);
        check("clkref_stop_ack", ack[0], 0);
      end
    end
    clkref_stop = 0;
    wait_ack(0);
    req[0] = 0;
    repeat (2) wait_slot();

    // reset in the middle of a write slot
    addr[2] = 25'h0000AB; din[2] = 8'h3E; we[2] = 1; req[2] = 1;
    n = 0;
    while (mem_we !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (m_ph != 3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    reset = 1;
    @(negedge clk);
    check("reset_we_drop", mem_we, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    acks = 0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (ack[2] === 1'b1) acks++;
      if (mem_we === 1'b1 && mem_addr == 25'h0000AB) break;
      n++;
    end
    check("reset_no_ack", acks, 0);
    check("reset_regrant", {mem_we, mem_addr}, {1'b1, 25'h0000AB});
    wait_ack(2);
    req[2] = 0;
    repeat (2) wait_slot();

    // random traffic on all ports
    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (req[p]) begin
          if (e_ack[p]) begin
            if ($urandom_range(0, 1) == 0) req[p] = 0;
            else new_txn(p);
          end
        end else if ($urandom_range(0, 5) == 0) begin
          new_txn(p);
          req[p] = 1;
        end
      end
    end
    for (int p = 0; p < 3; p++) req[p] = 0;
    repeat (3) wait_slot();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
